// File: rtl/alarm_controller.sv
// Car-alarm supervisory FSM: owns the four time parameters, requests timer loads
// and drives siren, status LED and the display state code.
module alarm_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    input  logic       one_hz_enable,
    output logic       start_timer,
    output logic [3:0] value,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_code
);

    typedef enum logic [2:0] {
        S_ARMED      = 3'd0,
        S_TRIGGERED  = 3'd1,
        S_ALARM      = 3'd2,
        S_DISARMED   = 3'd3,
        S_WAIT_OPEN  = 3'd4,
        S_WAIT_CLOSE = 3'd5,
        S_ARM_DELAY  = 3'd6
    } state_t;

    localparam logic [1:0] SEL_ARM_DELAY = 2'd0;
    localparam logic [1:0] SEL_DRIVER    = 2'd1;
    localparam logic [1:0] SEL_PASSENGER = 2'd2;
    localparam logic [1:0] SEL_ALARM_ON  = 2'd3;

    function automatic logic [3:0] default_param(input logic [1:0] sel);
        case (sel)
            SEL_ARM_DELAY: default_param = 4'd6;
            SEL_DRIVER:    default_param = 4'd8;
            SEL_PASSENGER: default_param = 4'd15;
            default:       default_param = 4'd10;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] value_q, value_d;
    logic       siren_q, siren_d;
    logic       led_q, led_d;
    logic       holdoff_q;
    logic [3:0] param_q [4];

    logic expired_ok;
    logic door_open;

    // The timer still shows the old count during the load cycle and the one after it.
    assign expired_ok = expired & ~start_q & ~holdoff_q;
    assign door_open  = door_driver | door_pass;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        value_d = value_q;

        if (reprogram) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (door_driver) begin
                        state_d = S_TRIGGERED;
                        start_d = 1'b1;
                        value_d = param_q[SEL_DRIVER];
                    end else if (door_pass) begin
                        state_d = S_TRIGGERED;
                        start_d = 1'b1;
                        value_d = param_q[SEL_PASSENGER];
                    end
                end
                S_TRIGGERED: begin
                    if (ignition) begin
                        state_d = S_DISARMED;
                    end else if (expired_ok) begin
                        state_d = S_ALARM;
                        start_d = 1'b1;
                        value_d = param_q[SEL_ALARM_ON];
                    end
                end
                S_ALARM: begin
                    if (ignition) begin
                        state_d = S_DISARMED;
                    end else if (expired_ok) begin
                        if (door_open) begin
                            start_d = 1'b1;
                            value_d = param_q[SEL_ALARM_ON];
                        end else begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_DISARMED: begin
                    if (!ignition) state_d = S_WAIT_OPEN;
                end
                S_WAIT_OPEN: begin
                    if (ignition)         state_d = S_DISARMED;
                    else if (door_driver) state_d = S_WAIT_CLOSE;
                end
                S_WAIT_CLOSE: begin
                    if (ignition) begin
                        state_d = S_DISARMED;
                    end else if (!door_open) begin
                        state_d = S_ARM_DELAY;
                        start_d = 1'b1;
                        value_d = param_q[SEL_ARM_DELAY];
                    end
                end
                S_ARM_DELAY: begin
                    if (ignition)        state_d = S_DISARMED;
                    else if (door_open)  state_d = S_WAIT_CLOSE;
                    else if (expired_ok) state_d = S_ARMED;
                end
                default: state_d = S_ARMED;
            endcase
        end

        siren_d = (state_d == S_ALARM);

        // LED is forced on when ARMED is (re)entered, then blinks on the 1 Hz tick.
        case (state_d)
            S_ARMED: begin
                if (state_q != S_ARMED || reprogram) led_d = 1'b1;
                else if (one_hz_enable)              led_d = ~led_q;
                else                                 led_d = led_q;
            end
            S_TRIGGERED, S_ALARM: led_d = 1'b1;
            default:              led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_ARMED;
            start_q   <= 1'b0;
            value_q   <= '0;
            siren_q   <= 1'b0;
            led_q     <= 1'b0;
            holdoff_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                param_q[i] <= default_param(2'(i));
            end
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            value_q   <= value_d;
            siren_q   <= siren_d;
            led_q     <= led_d;
            holdoff_q <= start_q;
            if (reprogram) begin
                param_q[time_param_sel] <= (time_value == '0) ? default_param(time_param_sel)
                                                              : time_value;
            end
        end
    end

    assign start_timer = start_q;
    assign value       = value_q;
    assign siren       = siren_q;
    assign status_led  = led_q;
    assign state_code  = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed walk through the alarm scenarios followed by random stimulus, all
// compared cycle by cycle against a behavioural model of the alarm rules.
module tb_alarm_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ignition = 1'b0, door_driver = 1'b0, door_pass = 1'b0, reprogram = 1'b0;
    logic [1:0] time_param_sel = '0;
    logic [3:0] time_value = '0;
    logic       expired = 1'b0, one_hz_enable = 1'b0;
    logic       start_timer, siren, status_led;
    logic [3:0] value;
    logic [2:0] state_code;

    alarm_controller dut (
        .clock(clock), .reset(reset), .ignition(ignition),
        .door_driver(door_driver), .door_pass(door_pass), .reprogram(reprogram),
        .time_param_sel(time_param_sel), .time_value(time_value),
        .expired(expired), .one_hz_enable(one_hz_enable),
        .start_timer(start_timer), .value(value), .siren(siren),
        .status_led(status_led), .state_code(state_code)
    );

    always #5 clock = ~clock;

    localparam int ARMED = 0, TRIGGERED = 1, ALARM = 2, DISARMED = 3;
    localparam int WAIT_OPEN = 4, WAIT_CLOSE = 5, ARM_DELAY = 6;
    localparam int DRV = 1, PAS = 2, AON = 3, ARMD = 0;

    int n_pass = 0;
    int n_total = 0;

    // Model: mode, expected outputs, and cycles elapsed since the last load pulse.
    int m_mode, m_value, m_age;
    bit m_start, m_siren, m_led;
    int m_par [4];
    int defaults [4] = '{6, 8, 15, 10};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = ARMED; m_value = 0; m_start = 0; m_siren = 0; m_led = 0;
        m_age = 2;
        for (int i = 0; i < 4; i++) m_par[i] = defaults[i];
    endtask

    task automatic check_all();
        chk("state_code",  8'(state_code),  8'(m_mode));
        chk("start_timer", 8'(start_timer), 8'(m_start));
        chk("value",       8'(value),       8'(m_value));
        chk("siren",       8'(siren),       8'(m_siren));
        chk("status_led",  8'(status_led),  8'(m_led));
    endtask

    task automatic step(input bit ig, input bit dd, input bit dp, input bit rp,
                        input int sel, input int tv, input bit ex, input bit tk);
        int  nxt;
        bit  ld;
        bit  qual;
        bit  any_door;
        ignition = ig; door_driver = dd; door_pass = dp; reprogram = rp;
        time_param_sel = 2'(sel); time_value = 4'(tv); expired = ex; one_hz_enable = tk;

        qual     = ex && (m_age >= 2);
        any_door = dd || dp;
        nxt      = m_mode;
        ld       = 0;
        if (rp) begin
            m_par[sel] = (tv == 0) ? defaults[sel] : tv;
            nxt = ARMED;
        end else if (m_mode == ARMED) begin
            if (dd)      begin nxt = TRIGGERED; ld = 1; m_value = m_par[DRV]; end
            else if (dp) begin nxt = TRIGGERED; ld = 1; m_value = m_par[PAS]; end
        end else if (ig) begin
            nxt = DISARMED;
        end else if (m_mode == DISARMED) begin
            nxt = WAIT_OPEN;
        end else if (m_mode == WAIT_OPEN) begin
            if (dd) nxt = WAIT_CLOSE;
        end else if (m_mode == WAIT_CLOSE) begin
            if (!any_door) begin nxt = ARM_DELAY; ld = 1; m_value = m_par[ARMD]; end
        end else if (m_mode == ARM_DELAY) begin
            if (any_door) nxt = WAIT_CLOSE;
            else if (qual) nxt = ARMED;
        end else if (m_mode == TRIGGERED) begin
            if (qual) begin nxt = ALARM; ld = 1; m_value = m_par[AON]; end
        end else if (m_mode == ALARM) begin
            if (qual) begin
                if (any_door) begin ld = 1; m_value = m_par[AON]; end
                else nxt = ARMED;
            end
        end

        if (nxt == TRIGGERED || nxt == ALARM) m_led = 1;
        else if (nxt == ARMED) m_led = (m_mode != ARMED || rp) ? 1'b1 : (m_led ^ tk);
        else m_led = 0;
        m_siren = (nxt == ALARM);
        m_start = ld;
        m_age   = ld ? 0 : ((m_age >= 2) ? 2 : m_age + 1);
        m_mode  = nxt;

        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input bit ex);
        step(0, 0, 0, 0, 0, 0, ex, 0);
    endtask

    initial begin
        bit ig_r, dd_r, dp_r;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_state", 8'(state_code), 8'd0);
        chk("rst_start", 8'(start_timer), 8'd0);
        chk("rst_value", 8'(value), 8'd0);
        chk("rst_siren", 8'(siren), 8'd0);
        chk("rst_led",   8'(status_led), 8'd0);
        reset = 1'b0;

        // driver-door trigger with expired held high
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("drv_value", 8'(value), 8'd8);
        chk("drv_state", 8'(state_code), 8'd1);
        idle(1);
        idle(1);
        chk("holdoff_state", 8'(state_code), 8'd1);
        idle(1);
        chk("alarm_state", 8'(state_code), 8'd2);
        chk("alarm_siren", 8'(siren), 8'd1);
        chk("alarm_value", 8'(value), 8'd10);

        // alarm extension then disarm to ARMED
        idle(1);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 1, 0);
        chk("ext_start", 8'(start_timer), 8'd1);
        chk("ext_state", 8'(state_code), 8'd2);
        idle(1);
        idle(1);
        idle(1);
        chk("rearm_state", 8'(state_code), 8'd0);
        chk("rearm_siren", 8'(siren), 8'd0);

        // LED blink in ARMED
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // simultaneous doors, then disarm / re-arm walk
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("both_value", 8'(value), 8'd8);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("disarm", 8'(state_code), 8'd3);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("armdly_state", 8'(state_code), 8'd6);
        chk("armdly_value", 8'(value), 8'd6);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("armdly_door", 8'(state_code), 8'd5);
        chk("armdly_noload", 8'(start_timer), 8'd0);
        idle(1);
        idle(1);
        idle(1);
        idle(1);
        chk("armdly_done", 8'(state_code), 8'd0);

        // passenger-only trigger, then reprogram from ALARM
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("pas_value", 8'(value), 8'd15);
        idle(1);
        idle(1);
        idle(1);
        step(0, 0, 0, 1, 1, 3, 1, 0);
        chk("rp_state", 8'(state_code), 8'd0);
        chk("rp_siren", 8'(siren), 8'd0);
        chk("rp_noload", 8'(start_timer), 8'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rp_value3", 8'(value), 8'd3);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rp_default", 8'(value), 8'd8);
        idle(1);
        idle(1);
        idle(1);

        // asynchronous reset while in ALARM
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 8'(state_code), 8'd0);
        chk("arst_siren", 8'(siren), 8'd0);
        chk("arst_start", 8'(start_timer), 8'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) idle(0);

        // random stimulus
        ig_r = 0; dd_r = 0; dp_r = 0;
        for (int n = 0; n < 600; n++) begin
            bit rp_r;
            int tv_r;
            if ($urandom_range(0, 9) == 0) ig_r = ~ig_r;
            if ($urandom_range(0, 3) == 0) dd_r = ~dd_r;
            if ($urandom_range(0, 3) == 0) dp_r = ~dp_r;
            rp_r = ($urandom_range(0, 29) == 0);
            tv_r = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
            step(ig_r, dd_r, dp_r, rp_r, int'($urandom_range(0, 3)), tv_r,
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
